// File: rtl/deal_sequencer_if.sv
// Signal bundle between the blackjack game FSM, the LFSR card source and the deal sequencer.
// Signal suffixes are named from the sequencer's point of view.
interface deal_sequencer_if;
   logic [3:0] card_rnd_i;
   logic       card_rdy_i;
   logic       card_used_o;
   logic       deck_rst_o;
   logic       new_round_i;
   logic       player_hit_i;
   logic       dealer_hit_i;
   logic [3:0] card_val_o;
   logic       card_dest_o;
   logic       card_valid_o;
   logic [5:0] dealt_o;
   logic       busy_o;
   logic       full_err_o;
   logic       tmo_o;

   modport master (
      output card_rnd_i, card_rdy_i, new_round_i, player_hit_i, dealer_hit_i,
      input  card_used_o, deck_rst_o, card_val_o, card_dest_o, card_valid_o,
             dealt_o, busy_o, full_err_o, tmo_o
   );

   modport slave (
      input  card_rnd_i, card_rdy_i, new_round_i, player_hit_i, dealer_hit_i,
      output card_used_o, deck_rst_o, card_val_o, card_dest_o, card_valid_o,
             dealt_o, busy_o, full_err_o, tmo_o
   );
endinterface

// File: rtl/deal_sequencer.sv
// Deal sequencer for one blackjack table: opening deal P,D,P,D, hit arbitration,
// dealt-card accounting and reshuffle pulses toward the LFSR card source.
module deal_sequencer #(
   parameter int unsigned DECK_SIZE = 52,
   parameter int unsigned RESHUF_AT = 40,
   parameter int unsigned TIMEOUT   = 1023
) (
   input  logic             clk_i,
   input  logic             rst_i,
   deal_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {INIT_SHUF, IDLE, SHUF, FETCH, ACK} state_e;

   localparam logic [5:0] DECK_MAX   = 6'(DECK_SIZE);
   localparam logic [6:0] RESHUF_LIM = 7'(RESHUF_AT);
   localparam logic [9:0] WD_MAX     = 10'(TIMEOUT);

   state_e     state_q, state_d;
   logic [5:0] dealt_q, dealt_d;
   logic [2:0] q_cnt_q, q_cnt_d;
   logic [3:0] q_dest_q, q_dest_d;
   logic       p_pend_q, p_pend_d;
   logic       d_pend_q, d_pend_d;
   logic [9:0] wd_q, wd_d;
   logic [3:0] card_val_q, card_val_d;
   logic       card_dest_q, card_dest_d;
   logic       used_q, used_d;
   logic       full_err_q, full_err_d;
   logic       tmo_q, tmo_d;

   logic       p_req, d_req;
   logic [6:0] dealt_ext;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      dealt_d     = dealt_q;
      q_cnt_d     = q_cnt_q;
      q_dest_d    = q_dest_q;
      p_pend_d    = p_pend_q | bus.player_hit_i;
      d_pend_d    = d_pend_q | bus.dealer_hit_i;
      wd_d        = '0;
      card_val_d  = card_val_q;
      card_dest_d = card_dest_q;
      full_err_d  = 1'b0;
      tmo_d       = tmo_q;
      p_req       = p_pend_q | bus.player_hit_i;
      d_req       = d_pend_q | bus.dealer_hit_i;
      dealt_ext   = {1'b0, dealt_q};

      case (state_q)
         INIT_SHUF: begin
            dealt_d = '0;
            state_d = IDLE;
         end
         IDLE: begin
            if (bus.new_round_i) begin
               p_pend_d = 1'b0;
               d_pend_d = 1'b0;
               q_cnt_d  = 3'd4;
               q_dest_d = 4'b1010;   // LSB first: player, dealer, player, dealer
               if (dealt_ext >= RESHUF_LIM || dealt_ext + 7'd4 > {1'b0, DECK_MAX})
                  state_d = SHUF;
               else
                  state_d = FETCH;
            end else if (p_req || d_req) begin
               if (p_req) p_pend_d = 1'b0;
               else       d_pend_d = 1'b0;
               if (dealt_q == DECK_MAX) begin
                  full_err_d = 1'b1;
               end else begin
                  q_cnt_d  = 3'd1;
                  q_dest_d = {3'b000, ~p_req};
                  state_d  = FETCH;
               end
            end
         end
         SHUF: begin
            dealt_d = '0;
            state_d = FETCH;
         end
         FETCH: begin
            if (bus.card_rdy_i) begin
               card_val_d  = bus.card_rnd_i;
               card_dest_d = q_dest_q[0];
               q_dest_d    = q_dest_q >> 1;
               q_cnt_d     = q_cnt_q - 3'd1;
               state_d     = ACK;
            end else if (wd_q == WD_MAX) begin
               tmo_d    = 1'b1;
               q_cnt_d  = '0;
               q_dest_d = '0;
               p_pend_d = 1'b0;
               d_pend_d = 1'b0;
               state_d  = IDLE;
            end else begin
               wd_d = wd_q + 10'd1;
            end
         end
         ACK: begin
            if (dealt_q != DECK_MAX) dealt_d = dealt_q + 6'd1;
            state_d = (q_cnt_q != 3'd0) ? FETCH : IDLE;
         end
         default: state_d = INIT_SHUF;
      endcase

      used_d = (state_d == ACK);
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) begin
         state_q     <= INIT_SHUF;
         dealt_q     <= '0;
         q_cnt_q     <= '0;
         q_dest_q    <= '0;
         p_pend_q    <= 1'b0;
         d_pend_q    <= 1'b0;
         wd_q        <= '0;
         card_val_q  <= '0;
         card_dest_q <= 1'b0;
         used_q      <= 1'b0;
         full_err_q  <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         dealt_q     <= dealt_d;
         q_cnt_q     <= q_cnt_d;
         q_dest_q    <= q_dest_d;
         p_pend_q    <= p_pend_d;
         d_pend_q    <= d_pend_d;
         wd_q        <= wd_d;
         card_val_q  <= card_val_d;
         card_dest_q <= card_dest_d;
         used_q      <= used_d;
         full_err_q  <= full_err_d;
         tmo_q       <= tmo_d;
      end
   end

   // State sits in INIT_SHUF while reset is held; gate so outputs read 0 until release.
   assign bus.deck_rst_o   = (state_q == SHUF) || (state_q == INIT_SHUF && !rst_i);
   assign bus.busy_o       = (state_q != IDLE) && !rst_i;
   assign bus.card_used_o  = used_q;
   assign bus.card_valid_o = used_q;
   assign bus.card_val_o   = card_val_q;
   assign bus.card_dest_o  = card_dest_q;
   assign bus.dealt_o      = dealt_q;
   assign bus.full_err_o   = full_err_q;
   assign bus.tmo_o        = tmo_q;
endmodule
